// File: rtl/tl_reg_bridge_if.sv
// Request (A) and response (D) channels between a TileLink-UL style master and tl_reg_bridge.
interface tl_reg_bridge_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
);
  localparam int unsigned MW = DW / 8;

  logic          a_valid;
  logic          a_ready;
  logic [3:0]    a_opcode;
  logic [MW-1:0] a_mask;
  logic [AW-1:0] a_address;
  logic [DW-1:0] a_data;

  logic          d_valid;
  logic          d_ready;
  logic [3:0]    d_opcode;
  logic          d_error;
  logic [DW-1:0] d_data;

  modport master (
    output a_valid, a_opcode, a_mask, a_address, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_error, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_mask, a_address, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_error, d_data
  );
endinterface

// File: rtl/tl_reg_bridge.sv
// Request-to-register-port bridge: decode stage, read-sample stage and an in-order
// response FIFO, admission limited so no more than DEPTH requests are ever in flight.
module tl_reg_bridge #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 4,
  parameter int unsigned NREG  = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  tl_reg_bridge_if.slave  tl,
  output logic            reg_wr,
  output logic            reg_rd,
  output logic [DW/8-1:0] reg_byte,
  output logic [AW-1:0]   reg_addr,
  output logic [DW-1:0]   reg_wdata,
  input  logic [DW-1:0]   reg_rdata
);
  localparam int unsigned MW = DW / 8;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(DEPTH + 3);

  localparam logic [3:0] OP_PUT_FULL = 4'd0;
  localparam logic [3:0] OP_PUT_PART = 4'd1;
  localparam logic [3:0] OP_GET      = 4'd4;
  localparam logic [3:0] OP_ACK      = 4'd0;
  localparam logic [3:0] OP_ACK_DATA = 4'd1;

  typedef struct packed {
    logic [3:0]    opcode;
    logic          error;
    logic [DW-1:0] data;
  } rsp_t;

  logic          a_ready_c;
  logic          accept;
  logic          is_get;
  logic          is_put;
  logic          addr_ok;
  logic          wr_ok;
  logic          rd_ok;

  logic          s1_valid;
  logic          s1_get;
  logic          s1_err;
  logic          s2_valid;
  logic          s2_get;
  logic          s2_err;
  logic          s2_rd;
  logic [MW-1:0] s2_mask;

  rsp_t          push_rsp;
  rsp_t          head;
  rsp_t          fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic          d_valid_c;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Admission counts every request not yet popped from the FIFO, so the FIFO can never overflow.
  assign outstanding = OW'(s1_valid) + OW'(s2_valid) + OW'(count);
  assign a_ready_c   = !rst && (32'(outstanding) < DEPTH);
  assign tl.a_ready  = a_ready_c;

  always_comb begin
    accept  = tl.a_valid && a_ready_c;
    is_get  = (tl.a_opcode == OP_GET);
    is_put  = (tl.a_opcode == OP_PUT_FULL) || (tl.a_opcode == OP_PUT_PART);
    addr_ok = (32'(tl.a_address) < NREG);
    wr_ok   = is_put && addr_ok && (tl.a_mask != '0) &&
              ((tl.a_opcode != OP_PUT_FULL) || (tl.a_mask == '1));
    rd_ok   = is_get && addr_ok;
  end

  // Stage 1: register-port strobes; illegal requests travel on with no strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_get    <= 1'b0;
      s1_err    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_byte  <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      s1_valid <= accept;
      reg_wr   <= accept && wr_ok;
      reg_rd   <= accept && rd_ok;
      if (accept) begin
        s1_get    <= is_get;
        s1_err    <= !(wr_ok || rd_ok);
        reg_byte  <= tl.a_mask;
        reg_addr  <= tl.a_address;
        reg_wdata <= tl.a_data;
      end
    end
  end

  // Stage 2: reg_rdata is valid the cycle after reg_rd and is captured into the FIFO here.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_get   <= 1'b0;
      s2_err   <= 1'b0;
      s2_rd    <= 1'b0;
      s2_mask  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_get  <= s1_get;
        s2_err  <= s1_err;
        s2_rd   <= reg_rd;
        s2_mask <= reg_byte;
      end
    end
  end

  always_comb begin
    push_rsp        = '0;
    push_rsp.opcode = s2_get ? OP_ACK_DATA : OP_ACK;
    push_rsp.error  = s2_err;
    for (int i = 0; i < int'(MW); i++) begin
      push_rsp.data[8*i +: 8] = (s2_rd && s2_mask[i]) ? reg_rdata[8*i +: 8] : 8'h00;
    end
  end

  assign push      = s2_valid;
  assign d_valid_c = !rst && (count != '0);
  assign pop       = d_valid_c && tl.d_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_rsp;
  end

  // Head entry is never overwritten while present, so D payload holds under back-pressure.
  assign head        = fifo_mem[rd_ptr];
  assign tl.d_valid  = d_valid_c;
  assign tl.d_opcode = d_valid_c ? head.opcode : 4'h0;
  assign tl.d_error  = d_valid_c ? head.error : 1'b0;
  assign tl.d_data   = d_valid_c ? head.data : '0;
endmodule

// File: doc/tl_reg_bridge.md
TL_REG_BRIDGE -- requirements
Module: tl_reg_bridge

Interface
REQ-001 The module SHALL have parameter DW, default 32, meaning the data width in bits; DW is a multiple of 8.
REQ-002 The module SHALL have parameter AW, default 4, meaning the word-address width.
REQ-003 The module SHALL have parameter NREG, default 16, meaning the number of implemented registers; address a is legal iff a < NREG.
REQ-004 The module SHALL have parameter DEPTH, default 4, minimum 2, meaning the maximum number of outstanding requests.
REQ-005 The module SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all logic acts on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 a_valid in 1, a_ready out 1, a_opcode in 4, a_mask in DW/8, a_address in AW, a_data in DW  form the request channel.
REQ-009 d_valid out 1, d_ready in 1, d_opcode out 4, d_error out 1, d_data out DW  form the response channel.
REQ-010 reg_wr out 1, reg_rd out 1, reg_byte out DW/8, reg_addr out AW, reg_wdata out DW  form the register-port outputs; reg_rdata in DW is the register-port input.

Function
REQ-011 Request opcodes: PutFullData=0, PutPartialData=1, Get=4; any other value SHALL be illegal.
REQ-012 Response opcodes: AccessAck=0 (Put or illegal opcode), AccessAckData=1 (Get).
REQ-013 An A transfer SHALL occur in a cycle where a_valid && a_ready.
REQ-014 outstanding = stage1 valid + stage2 valid + FIFO count, all registered; a_ready SHALL be 1 iff outstanding < DEPTH, with no combinational path from d_ready.
REQ-015 Stage1, cycle N+1 after an A transfer in cycle N: for a legal request, exactly one of reg_wr or reg_rd SHALL be 1, with reg_addr=a_address, reg_byte=a_mask, reg_wdata=a_data.
REQ-016 Legal write = Put, address < NREG, mask != 0; PutFullData additionally requires mask all ones.
REQ-017 Legal read = Get, address < NREG; reg_byte SHALL carry a_mask.
REQ-018 Illegal requests SHALL keep reg_wr=reg_rd=0 and SHALL still produce a response with d_error=1.
REQ-019 Stage2, cycle N+2: for reads, reg_rdata SHALL be sampled, bytes with mask bit 0 SHALL be zeroed, and the response SHALL be written into the FIFO.
REQ-020 A Get with d_error=1 SHALL return d_data=0; an AccessAck SHALL return d_data=0.
REQ-021 FIFO: DEPTH entries of {opcode, error, data}, circular read/write pointers that wrap at DEPTH.
REQ-022 d_valid SHALL equal FIFO not empty; minimum request-to-d_valid latency SHALL be 3 cycles (d_valid in cycle N+3).
REQ-023 A pop SHALL occur on d_valid && d_ready; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-024 d_opcode, d_error and d_data SHALL hold stable while d_valid && !d_ready.
REQ-025 Responses SHALL return in request order.
REQ-026 Sustained throughput SHALL be 1 transfer per cycle when d_ready=1 and DEPTH>=4.
REQ-027 Overflow SHALL be impossible by construction; no request SHALL be dropped.

Reset
REQ-028 While rst=1: a_ready=0, d_valid=0, reg_wr=reg_rd=0, reg_byte=0, reg_addr=0, reg_wdata=0, d_opcode=0, d_error=0, d_data=0; pipeline stages and FIFO SHALL be emptied and pointers zeroed.
REQ-029 A reset asserted mid-transaction SHALL discard all in-flight requests and responses; no reg_wr SHALL issue in the cycle after rst falls.
REQ-030 In the first cycle after rst deasserts, a_ready SHALL be 1.

Verification
REQ-031 PutFullData addr=3, mask=F, data=0xDEADBEEF -> reg_wr=1 at N+1 with addr=3, byte=F; d_valid at N+3 with opcode=0, error=0.
REQ-032 Get addr=3, mask=3, reg_rdata=0xDEADBEEF -> reg_rd at N+1; AccessAckData at N+3 with d_data=0x0000BEEF.
REQ-033 Get addr=NREG (16, AW=5 build) and opcode=7 -> no reg strobe; responses error=1, opcodes 1 then 0, data=0.
REQ-034 d_ready=0 with 6 back-to-back Gets, DEPTH=4 -> a_ready=0 after 4 accepts; raise d_ready -> all 6 returned in order, no loss.
REQ-035 d_ready=1 with 8 consecutive Puts at DEPTH=4 -> a_ready stays 1 and 8 responses arrive on 8 consecutive cycles.
REQ-036 rst pulsed at N+1 of a Put -> d_valid never rises for it; a_ready=1 on the first post-reset cycle.
